gen_chan_capture: RTL
=====================

Name: gen_chan_capture

Overview:
Parametrised multi-channel bit-vector capture bank. A shared input register feeds NCH generate-replicated channels. Each channel transforms the vector by a per-channel mode (invert, pass, sticky-OR, rising-edge) on its own capture enable, and keeps a saturating popcount accumulator. It is the generalised channel-array block used by the bench tops and channel-array tests.

Parameters:
WIDTH, 10, bits per input vector and per channel output (>=1)
NCH, 2, number of channels (>=1)
CNT_W, 16, width of per-channel popcount accumulator (>=$clog2(WIDTH+1))

Ports:
clk  input  1  sole clock, all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state
in  input  WIDTH  data vector, sampled every cycle
cap_en  input  NCH  per-channel capture request, bit c = channel c
mode  input  2*NCH  per-channel mode, channel c at [2c+1:2c]
clr  input  NCH  per-channel synchronous clear
out  output  NCH*WIDTH  channel c result at [c*WIDTH +: WIDTH]
valid  output  NCH  one-cycle pulse: channel c out updated this cycle
cnt  output  NCH*CNT_W  channel c popcount accumulator
ovf  output  NCH  sticky saturation flag per channel

Behaviour:
- Reset: asynchronous, active-high, clk is the only clock. a_q, a_prev, out, valid, cnt and ovf all go to 0 immediately and hold while reset is high.
- Shared front end, every cycle: a_q <= in; a_prev <= a_q. edge = a_q & ~a_prev.
- Latency: in applied before edge N is captured in a_q at edge N. A channel with cap_en=1 at edge N+1 updates out at edge N+1, and valid is high for the cycle after edge N+1.
- Modes, evaluated per bit from a_q at the capture edge:
  0 INVERT: out <= ~a_q
  1 PASS: out <= a_q
  2 STICKY: out <= out | a_q
  3 EDGE: out <= edge
- Capture when cap_en[c]=1 and clr[c]=0:
  - out updates as above; valid[c] <= 1.
  - cnt[c] <= cnt + popcount(new out), saturating at 2^CNT_W-1.
  - If the true sum exceeds the maximum, cnt holds the maximum and ovf[c] <= 1.
- No capture: out and cnt hold; valid[c] <= 0.
- clr[c]=1: out, cnt, ovf and valid of channel c <= 0. clr wins over a simultaneous cap_en. Other channels are unaffected, and a_q/a_prev are unaffected.
- Mode change: takes effect at the next capture; no state flush. STICKY entered mid-stream ORs into the existing out.
- After reset, a_prev=0, so the first EDGE capture reports every 1-bit of a_q.
- Channels are fully independent; any combination of simultaneous cap_en/clr across channels is legal.
- ovf is sticky; only clr or reset clears it.
- Reset asserted mid-operation discards pending captures. No valid pulse is emitted on the cycle reset deasserts.

Decomposition:
- Shared package gen_chan_pkg holds:
  - mode encodings MODE_INVERT=2'd0, MODE_PASS=2'd1, MODE_STICKY=2'd2, MODE_EDGE=2'd3
  - a popcount function parametrised by WIDTH
- One sub-module gen_chan_slice contains the per-channel out/valid/cnt/ovf logic. It is instantiated NCH times in a generate-for; the top holds a_q/a_prev.

Test Plan:
- Reset/INVERT: WIDTH=10, NCH=2, mode all 0. in=10'h3F0 at edge 1; cap_en=2'b11 at edge 2 -> out[0]=out[1]=10'h00F, valid=2'b11 for one cycle, cnt=4 each.
- PASS then STICKY: ch0 mode=1, in=10'h001 captured -> out=10'h001. Switch to mode=2, in=10'h200 captured -> out=10'h201, cnt=1+2=3.
- EDGE after reset: mode=3, in held 10'h005 for 3 cycles, cap_en every cycle -> out=10'h005 on the first capture, then 10'h000; cnt stays 2.
- Saturation: CNT_W=4, INVERT, in=0 (popcount 10) captured twice -> cnt 10 then 15, ovf=1. A further capture keeps cnt=15 and ovf=1.
- clr priority and independence: ch0 clr=1 and cap_en=1 same edge, ch1 cap_en=1 -> ch0 out=0, cnt=0, ovf=0, valid[0]=0; ch1 updates normally with valid[1]=1.
- Async reset mid-run: assert reset between edges with cnt nonzero -> all outputs 0 before the next clk edge. Deassert with cap_en held -> first valid only after a fresh in sample (two edges).

Source files
------------

// File: rtl/gen_chan_pkg.sv
// gen_chan_pkg: mode encodings and popcount shared by the channel capture bank
package gen_chan_pkg;
  typedef enum logic [1:0] {
    MODE_INVERT = 2'd0,
    MODE_PASS   = 2'd1,
    MODE_STICKY = 2'd2,
    MODE_EDGE   = 2'd3
  } mode_t;
  localparam int MAX_W = 1024;
  function automatic int popcount(input logic [MAX_W-1:0] v, input int width);
    popcount = 0;
    for (int i = 0; i < MAX_W; i++)
      if (i < width) popcount += 32'(v[i]);
  endfunction
endpackage

// File: rtl/gen_chan_capture_slice.sv
// gen_chan_slice: one channel's mode transform, valid pulse and saturating popcount
module gen_chan_slice
  import gen_chan_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_q,
  input  logic [WIDTH-1:0] rise,
  input  logic             cap,
  input  logic             clr,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);
  logic [WIDTH-1:0] nxt;
  logic [MAX_W-1:0] ext;
  logic [CNT_W:0]   sum;
  always_comb begin
    nxt = mode == MODE_INVERT ? ~a_q : mode == MODE_PASS ? a_q : mode == MODE_STICKY ? out | a_q : rise;
    ext = '0;
    ext[WIDTH-1:0] = nxt;
    sum = {1'b0, cnt} + (CNT_W+1)'(popcount(ext, WIDTH));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out   <= '0;
      valid <= 1'b0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      out   <= '0;
      valid <= 1'b0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (cap) begin
      out   <= nxt;
      valid <= 1'b1;
      cnt   <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      if (sum[CNT_W]) ovf <= 1'b1;
    end else begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/gen_chan_capture.sv
// gen_chan_capture: shared input register feeding NCH independent capture channels
module gen_chan_capture
  import gen_chan_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int NCH   = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in,
  input  logic [NCH-1:0]       cap_en,
  input  logic [2*NCH-1:0]     mode,
  input  logic [NCH-1:0]       clr,
  output logic [NCH*WIDTH-1:0] out,
  output logic [NCH-1:0]       valid,
  output logic [NCH*CNT_W-1:0] cnt,
  output logic [NCH-1:0]       ovf
);
  logic [WIDTH-1:0] a_q, a_prev, rise;
  logic             a_ok;
  assign rise = a_q & ~a_prev;
  // a_ok blocks captures until a_q holds a real sample after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      a_prev <= '0;
      a_ok   <= 1'b0;
    end else begin
      a_q    <= in;
      a_prev <= a_q;
      a_ok   <= 1'b1;
    end
  end
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    gen_chan_slice #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slice (
      .clk   (clk),
      .reset (reset),
      .a_q   (a_q),
      .rise  (rise),
      .cap   (cap_en[c] & a_ok),
      .clr   (clr[c]),
      .mode  (mode[2*c +: 2]),
      .out   (out[c*WIDTH +: WIDTH]),
      .valid (valid[c]),
      .cnt   (cnt[c*CNT_W +: CNT_W]),
      .ovf   (ovf[c])
    );
  end
endmodule
